// File: rtl/dsp_pkg.sv
// Shared fixed-point constants and types for the DSP datapath blocks.
package dsp_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned FRAC_W  = 16;
   localparam int unsigned GUARD_W = 8;
   localparam int unsigned ACC_W   = DATA_W + GUARD_W;

   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/dsp_sat.sv
// Clamp a guarded accumulator to a signed DATA_W sample; flags when clamping occurred.
module dsp_sat #(
   parameter int unsigned DATA_W  = dsp_pkg::DATA_W,
   parameter int unsigned GUARD_W = dsp_pkg::GUARD_W
) (
   input  logic [DATA_W+GUARD_W-1:0] i_acc,
   output logic [DATA_W-1:0]         o_data_c,
   output logic                      o_sat_c
);

   localparam int unsigned ACC_W = DATA_W + GUARD_W;

   logic [GUARD_W:0] w_top;
   logic             w_fits;

   // The value fits when the guard bits are pure sign extension.
   always_comb begin
      w_top    = i_acc[ACC_W-1:DATA_W-1];
      w_fits   = (&w_top) || (~|w_top);
      o_sat_c  = !w_fits;
      if (w_fits)
         o_data_c = i_acc[DATA_W-1:0];
      else if (i_acc[ACC_W-1])
         o_data_c = {1'b1, {(DATA_W-1){1'b0}}};
      else
         o_data_c = {1'b0, {(DATA_W-1){1'b1}}};
   end

endmodule

// File: rtl/mac_accum.sv
// Accumulates a stream of signed Q15.16 terms and presents one saturated sum per packet.
module mac_accum
   import dsp_pkg::*;
#(
   parameter int unsigned DATA_W    = dsp_pkg::DATA_W,
   parameter int unsigned GUARD_W   = dsp_pkg::GUARD_W,
   parameter int unsigned MAX_TERMS = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_sat,
   output logic [$clog2(MAX_TERMS):0]   out_count
);

   localparam int unsigned ACC_W = DATA_W + GUARD_W;
   localparam int unsigned CNT_W = $clog2(MAX_TERMS) + 1;

   state_t             r_state, w_state_next;
   logic [ACC_W-1:0]   r_acc, w_acc_next, w_sum;
   logic [CNT_W-1:0]   r_count, w_count_next, w_count_inc;
   logic               r_out_valid;
   logic [DATA_W-1:0]  r_out_data;
   logic               r_out_sat;
   logic [CNT_W-1:0]   r_out_count;
   logic               w_accept, w_load, w_release;
   logic [DATA_W-1:0]  w_sat_data;
   logic               w_sat_flag;

   assign in_ready  = (r_state != ST_HOLD);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign out_count = r_out_count;

   dsp_sat #(
      .DATA_W  (DATA_W),
      .GUARD_W (GUARD_W)
   ) u_sat (
      .i_acc    (w_sum),
      .o_data_c (w_sat_data),
      .o_sat_c  (w_sat_flag)
   );

   // Next-state and accumulator update; clear overrides everything.
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_count_next = r_count;
      w_load       = 1'b0;
      w_release    = 1'b0;
      w_accept     = in_valid && in_ready;
      w_sum        = ((r_state == ST_IDLE) ? ACC_W'(0) : r_acc)
                     + {{GUARD_W{in_data[DATA_W-1]}}, in_data};
      w_count_inc  = (r_state == ST_IDLE) ? CNT_W'(1) : (r_count + CNT_W'(1));

      case (r_state)
         ST_IDLE, ST_ACCUM: begin
            if (w_accept) begin
               w_acc_next   = w_sum;
               w_count_next = w_count_inc;
               if (in_last || (w_count_inc == CNT_W'(MAX_TERMS))) begin
                  w_state_next = ST_HOLD;
                  w_load       = 1'b1;
               end else begin
                  w_state_next = ST_ACCUM;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               w_state_next = ST_IDLE;
               w_acc_next   = '0;
               w_count_next = '0;
               w_release    = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_acc_next   = '0;
            w_count_next = '0;
         end
      endcase

      if (clear) begin
         w_state_next = ST_IDLE;
         w_acc_next   = '0;
         w_count_next = '0;
         w_load       = 1'b0;
         w_release    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_acc   <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_count <= w_count_next;
      end
   end

   // Result registers stay frozen while the sum is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_out_count <= '0;
      end else if (clear) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sat_data;
         r_out_sat   <= w_sat_flag;
         r_out_count <= w_count_next;
      end else if (w_release) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
